// File: rtl/timer_setup_panel.sv
// Countdown-timer front panel: debounced buttons edit the min/sec preset and issue start/pause/stop pulses.
// Button-to-action latency is 2 + DEBOUNCE_CYCLES + 2 cycles; all outputs are registered.
module timer_setup_panel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_MIN         = 99,
  parameter int MAX_SEC         = 59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       btn_go,
  input  logic       btn_halt,
  input  logic       done,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic       start,
  output logic       pause,
  output logic       stop,
  output logic       field,
  output logic [1:0] state
);

  typedef enum logic [1:0] {EDIT = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10} panel_state_t;
  typedef enum logic [2:0] {ACT_NONE, ACT_HALT, ACT_GO, ACT_SEL, ACT_UP, ACT_DOWN} act_t;

  localparam int NB     = 5;
  localparam int B_UP   = 0;
  localparam int B_DOWN = 1;
  localparam int B_SEL  = 2;
  localparam int B_GO   = 3;
  localparam int B_HALT = 4;
  localparam int CW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] MIN_TOP = 7'(MAX_MIN);
  localparam logic [6:0] SEC_TOP = 7'(MAX_SEC);

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1, sync2, deb, deb_d, strb;
  logic [CW-1:0] cnt [NB];
  logic          done_s1, done_s2, done_d, done_rise;

  panel_state_t state_q, state_n;
  act_t         act;
  logic [6:0]   min_n, sec_n;
  logic         field_n, start_n, pause_n, stop_n;

  assign raw = {btn_halt, btn_go, btn_sel, btn_down, btn_up};

  // Debounced level flips after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // the strobe is registered once more so it lands the cycle after the rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      strb  <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      strb  <= deb & ~deb_d;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          deb[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_d  <= 1'b0;
    end else begin
      done_s1 <= done;
      done_s2 <= done_s1;
      done_d  <= done_s2;
    end
  end

  assign done_rise = done_s2 & ~done_d;

  always_comb begin
    act = ACT_NONE;
    if (strb[B_HALT])      act = ACT_HALT;
    else if (strb[B_GO])   act = ACT_GO;
    else if (strb[B_SEL])  act = ACT_SEL;
    else if (strb[B_UP])   act = ACT_UP;
    else if (strb[B_DOWN]) act = ACT_DOWN;
  end

  function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] vmax, input logic dn);
    if (dn) return (v == 7'd0) ? vmax : v - 7'd1;
    else    return (v >= vmax) ? 7'd0 : v + 7'd1;
  endfunction

  always_comb begin
    state_n = state_q;
    min_n   = min;
    sec_n   = sec;
    field_n = field;
    start_n = 1'b0;
    pause_n = 1'b0;
    stop_n  = 1'b0;
    case (state_q)
      EDIT: begin
        case (act)
          ACT_HALT: begin
            min_n   = '0;
            sec_n   = '0;
            field_n = 1'b0;
          end
          ACT_GO: begin
            if (min != '0 || sec != '0) begin
              start_n = 1'b1;
              state_n = RUNNING;
            end
          end
          ACT_SEL: field_n = ~field;
          ACT_UP, ACT_DOWN: begin
            if (field) sec_n = step(sec, SEC_TOP, act == ACT_DOWN);
            else       min_n = step(min, MIN_TOP, act == ACT_DOWN);
          end
          default: ;
        endcase
      end
      RUNNING: begin
        if (act == ACT_HALT) begin
          stop_n  = 1'b1;
          state_n = EDIT;
          field_n = 1'b0;
        end else if (act == ACT_GO) begin
          pause_n = 1'b1;
          state_n = PAUSED;
        end else if (done_rise) begin
          state_n = EDIT;
          field_n = 1'b0;
        end
      end
      PAUSED: begin
        if (act == ACT_HALT) begin
          stop_n  = 1'b1;
          state_n = EDIT;
          field_n = 1'b0;
        end else if (act == ACT_GO) begin
          start_n = 1'b1;
          state_n = RUNNING;
        end
      end
      default: state_n = EDIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EDIT;
      min     <= '0;
      sec     <= '0;
      field   <= 1'b0;
      start   <= 1'b0;
      pause   <= 1'b0;
      stop    <= 1'b0;
    end else begin
      state_q <= state_n;
      min     <= min_n;
      sec     <= sec_n;
      field   <= field_n;
      start   <= start_n;
      pause   <= pause_n;
      stop    <= stop_n;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_timer_setup_panel.sv
// Bench for timer_setup_panel: a reference model queues expected output snapshots with their cycle stamps.
module tb_timer_setup_panel;

  logic       clock, reset;
  logic       btn_up, btn_down, btn_sel, btn_go, btn_halt, done;
  logic [6:0] min, sec;
  logic       start, pause, stop, field;
  logic [1:0] state;

  timer_setup_panel #(.DEBOUNCE_CYCLES(4), .MAX_MIN(99), .MAX_SEC(59)) dut (
    .clock(clock), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel), .btn_go(btn_go), .btn_halt(btn_halt),
    .done(done),
    .min(min), .sec(sec), .start(start), .pause(pause), .stop(stop), .field(field), .state(state)
  );

  localparam logic [4:0] UP   = 5'b00001;
  localparam logic [4:0] DN   = 5'b00010;
  localparam logic [4:0] SEL  = 5'b00100;
  localparam logic [4:0] GO   = 5'b01000;
  localparam logic [4:0] HALT = 5'b10000;

  typedef struct packed {
    logic [6:0] mn;
    logic [6:0] sc;
    logic       fld;
    logic [1:0] st;
    logic       p_start;
    logic       p_pause;
    logic       p_stop;
  } snap_t;

  typedef struct {
    snap_t s;
    int    at;
  } exp_t;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  snap_t cur, prev;
  exp_t  e;

  int         m_min, m_sec;
  logic       m_field;
  logic [1:0] m_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic snap_t mk(input logic s, input logic p, input logic t);
    snap_t r;
    r.mn = 7'(m_min);
    r.sc = 7'(m_sec);
    r.fld = m_field;
    r.st = m_state;
    r.p_start = s;
    r.p_pause = p;
    r.p_stop = t;
    return r;
  endfunction

  function automatic snap_t outs();
    return {min, sec, field, state, start, pause, stop};
  endfunction

  task automatic model_reset();
    m_min = 0;
    m_sec = 0;
    m_field = 1'b0;
    m_state = 2'b00;
  endtask

  task automatic model_apply(input logic [4:0] mask, input int t0);
    snap_t b, a;
    logic  s, p, t;
    s = 1'b0; p = 1'b0; t = 1'b0;
    b = mk(1'b0, 1'b0, 1'b0);
    if (m_state == 2'b00) begin
      if (mask[4]) begin
        m_min = 0; m_sec = 0; m_field = 1'b0;
      end else if (mask[3]) begin
        if (m_min != 0 || m_sec != 0) begin s = 1'b1; m_state = 2'b01; end
      end else if (mask[2]) begin
        m_field = ~m_field;
      end else if (mask[1]) begin
        if (!m_field) m_min = (m_min == 0) ? 99 : m_min - 1;
        else          m_sec = (m_sec == 0) ? 59 : m_sec - 1;
      end else if (mask[0]) begin
        if (!m_field) m_min = (m_min == 99) ? 0 : m_min + 1;
        else          m_sec = (m_sec == 59) ? 0 : m_sec + 1;
      end
    end else begin
      if (mask[4]) begin
        t = 1'b1; m_state = 2'b00; m_field = 1'b0;
      end else if (mask[3]) begin
        if (m_state == 2'b01) begin p = 1'b1; m_state = 2'b10; end
        else                  begin s = 1'b1; m_state = 2'b01; end
      end
    end
    a = mk(s, p, t);
    if (a != b) sb.push_back('{a, t0 + 8});
    if (s | p | t) sb.push_back('{mk(1'b0, 1'b0, 1'b0), t0 + 9});
  endtask

  task automatic drive(input logic [4:0] mask);
    {btn_halt, btn_go, btn_sel, btn_down, btn_up} = mask;
  endtask

  task automatic press(input logic [4:0] mask);
    int t0;
    @(posedge clock); #1;
    drive(mask);
    t0 = cyc;
    model_apply(mask, t0);
    repeat (10) @(posedge clock);
    #1 drive(5'b0);
    repeat (10) @(posedge clock);
  endtask

  task automatic pulse_done();
    int t0;
    @(posedge clock); #1;
    done = 1'b1;
    t0 = cyc;
    if (m_state == 2'b01) begin
      m_state = 2'b00;
      m_field = 1'b0;
      sb.push_back('{mk(1'b0, 1'b0, 1'b0), t0 + 3});
    end
    repeat (6) @(posedge clock);
    #1 done = 1'b0;
    repeat (4) @(posedge clock);
  endtask

  // Every observed change of the output vector must match the head of the scoreboard.
  always @(negedge clock) begin
    cur = outs();
    if (reset) begin
      prev = cur;
    end else if (cur !== prev) begin
      if (sb.size() == 0) begin
        chk("spurious_change", 32'(cur), 32'(prev));
      end else begin
        e = sb.pop_front();
        chk("outputs", 32'(cur), 32'(e.s));
        chk("event_cycle", 32'(cyc), 32'(e.at));
      end
      prev = cur;
    end
  end

  initial begin
    reset = 1'b1;
    done = 1'b0;
    drive(5'b0);
    model_reset();
    repeat (3) @(posedge clock);
    #1 chk("reset_outputs", 32'(outs()), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // first press: min=1 exactly 8 cycles after raw rise
    press(UP);
    // 3-cycle glitch must not debounce
    @(posedge clock); #1 btn_up = 1'b1;
    repeat (3) @(posedge clock);
    #1 btn_up = 1'b0;
    repeat (15) @(posedge clock);

    press(HALT);
    press(DN);
    press(SEL);
    for (int i = 0; i < 60; i++) press(UP);
    #1 chk("sec_wrapped", 32'(sec), 32'd0);
    chk("field_sec", 32'(field), 32'd1);

    press(HALT);
    press(GO);
    chk("go_zero_state", 32'(state), 32'd0);
    press(SEL);
    for (int i = 0; i < 5; i++) press(UP);
    press(GO);
    press(GO);
    pulse_done();
    press(SEL);
    press(UP);
    press(GO);
    press(HALT);
    #1 chk("retained_sec", 32'(sec), 32'd5);

    press(GO);
    pulse_done();
    press(GO);
    press(HALT | GO);
    press(GO);

    // async reset while go is held mid-debounce
    @(posedge clock); #1 btn_go = 1'b1;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1 chk("async_reset", 32'(outs()), 32'd0);
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (25) @(posedge clock);
    #1 btn_go = 1'b0;
    repeat (12) @(posedge clock);
    chk("post_reset_state", 32'(state), 32'd0);

    press(UP);
    press(DN);
    press(DN);
    repeat (5) @(posedge clock);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
